// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and load/store.
// Optional macro ARB_RR_EN: round-robin tie-break instead of data priority with fetch starvation guard.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_wen,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  m_en,
  output logic                  m_wen,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic [DATA_W-1:0]     m_rdata,
  output logic                  busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  owner_t owner_q, owner_d;
  logic   inst_win;

`ifdef ARB_RR_EN
  // 0: fetch held the last grant, 1: data did
  logic last_data_q, last_data_d;
`else
  logic [CNT_W-1:0] wait_q, wait_d;
`endif

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
`ifdef ARB_RR_EN
      last_data_q <= 1'b0;
`else
      wait_q <= '0;
`endif
    end else begin
      owner_q <= owner_d;
`ifdef ARB_RR_EN
      last_data_q <= last_data_d;
`else
      wait_q <= wait_d;
`endif
    end
  end

  // Grant decision, memory command mirror, read return steering and next state
  always_comb begin
    inst_win = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    m_en     = 1'b0;
    m_wen    = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    busy     = 1'b0;
    owner_d  = OWN_NONE;
`ifdef ARB_RR_EN
    last_data_d = last_data_q;
    inst_win    = !d_req || last_data_q;
`else
    wait_d   = '0;
    inst_win = !d_req || (wait_q == CNT_W'(MAX_WAIT));
`endif

    if (!rst) begin
      i_gnt = i_req && inst_win;
      d_gnt = d_req && !i_gnt;

      if (i_gnt) begin
        m_en    = 1'b1;
        m_addr  = i_addr;
        owner_d = OWN_INST;
      end else if (d_gnt) begin
        m_en   = 1'b1;
        m_wen  = d_wen;
        m_addr = d_addr;
        if (d_wen) begin
          m_wdata = d_wdata;
          m_wstrb = STRB_W'(d_wstrb);
        end else begin
          owner_d = OWN_DATA;
        end
      end

      i_rvalid = (owner_q == OWN_INST);
      d_rvalid = (owner_q == OWN_DATA);
      busy     = (owner_q != OWN_NONE);
      if (i_rvalid) i_rdata = m_rdata;
      if (d_rvalid) d_rdata = m_rdata;

`ifdef ARB_RR_EN
      if (i_gnt)      last_data_d = 1'b0;
      else if (d_gnt) last_data_d = 1'b1;
`else
      // Count consecutive denied fetch cycles, saturating at the forcing threshold
      if (i_req && !i_gnt) begin
        wait_d = (wait_q == CNT_W'(MAX_WAIT)) ? wait_q : wait_q + CNT_W'(1);
      end
`endif
    end
  end

endmodule
